// File: rtl/tug_game_controller_pkg.sv
// Shared encodings and constants for the tug-of-war game sequencer.
package tug_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_WIN       = 2'd3;

    localparam int         LED_W      = 7;
    localparam logic [2:0] CENTER_POS = 3'd3;
    localparam logic [2:0] POS_MAX    = 3'd6;
    localparam logic [2:0] POS_MIN    = 3'd0;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam logic [1:0] LEDCTL_OFF = 2'b00;
    localparam logic [1:0] LEDCTL_ON  = 2'b10;

    function automatic logic [LED_W-1:0] pos_to_score(input logic [2:0] pos);
        return 7'b0000001 << pos;
    endfunction

endpackage

// File: rtl/tug_game_controller_tick_counter.sv
// Loadable down-counter stepped by the slow tick; saturates at zero.
module tug_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    import tug_pkg::*;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tug_game_controller.sv
// Tug-of-war sequencer: countdown with false-start penalties, rope play, win flash.
module tug_game_controller
    import tug_pkg::*;
#(
    parameter int START_TICKS = 3,
    parameter int FLASH_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic             pbl,
    input  logic             pbr,
    output logic [LED_W-1:0] score,
    output logic [1:0]       led_control,
    output logic [1:0]       winner
);
    localparam int CNT_MAX = (START_TICKS > FLASH_TICKS) ? START_TICKS : FLASH_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       state_q,  state_d;
    logic [2:0]       pos_q,    pos_d;
    logic [LED_W-1:0] score_q,  score_d;
    logic [1:0]       led_q,    led_d;
    logic [1:0]       winner_q, winner_d;
    logic             pen_l_q,  pen_l_d;
    logic             pen_r_q,  pen_r_d;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_zero_s;

    tug_tick_counter #(.W(CNT_W)) u_tick_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .dec_i      (cnt_dec_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // Game FSM, rope position and output next-state
    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        led_d          = led_q;
        winner_d       = winner_q;
        pen_l_d        = pen_l_q;
        pen_r_d        = pen_r_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = CNT_W'(START_TICKS);
        cnt_dec_s      = 1'b0;

        if (clear) begin
            state_d    = ST_COUNTDOWN;
            pos_d      = CENTER_POS;
            led_d      = LEDCTL_OFF;
            winner_d   = WIN_NONE;
            pen_l_d    = 1'b0;
            pen_r_d    = 1'b0;
            cnt_load_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d = LEDCTL_OFF;
                end
                ST_COUNTDOWN: begin
                    led_d   = LEDCTL_OFF;
                    pen_l_d = pen_l_q | pbl;
                    pen_r_d = pen_r_q | pbr;
                    if (tick) begin
                        cnt_dec_s = 1'b1;
                        if (cnt_s == CNT_W'(1)) begin
                            state_d = ST_PLAY;
                            led_d   = LEDCTL_ON;
                            // The non-penalised player gains one step at the start
                            if (pen_l_d && !pen_r_d) begin
                                pos_d = CENTER_POS - 3'd1;
                            end else if (pen_r_d && !pen_l_d) begin
                                pos_d = CENTER_POS + 3'd1;
                            end else begin
                                pos_d = CENTER_POS;
                            end
                            pen_l_d = 1'b0;
                            pen_r_d = 1'b0;
                        end else begin
                            state_d = ST_COUNTDOWN;
                        end
                    end else begin
                        state_d = ST_COUNTDOWN;
                    end
                end
                ST_PLAY: begin
                    led_d = LEDCTL_ON;
                    if (pbl != pbr) begin
                        pos_d = pbl ? (pos_q + 3'd1) : (pos_q - 3'd1);
                        if (pos_d == POS_MAX) begin
                            state_d        = ST_WIN;
                            winner_d       = WIN_LEFT;
                            led_d          = 2'b11;
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = CNT_W'(FLASH_TICKS);
                        end else if (pos_d == POS_MIN) begin
                            state_d        = ST_WIN;
                            winner_d       = WIN_RIGHT;
                            led_d          = 2'b11;
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = CNT_W'(FLASH_TICKS);
                        end else begin
                            state_d = ST_PLAY;
                        end
                    end else begin
                        pos_d = pos_q;
                    end
                end
                ST_WIN: begin
                    led_d[0] = 1'b1;
                    if (tick && !cnt_zero_s) begin
                        cnt_dec_s = 1'b1;
                        led_d[1]  = ~led_q[1];
                    end else if (cnt_zero_s) begin
                        led_d[1] = 1'b1;
                    end else begin
                        led_d[1] = led_q[1];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = LEDCTL_OFF;
                end
            endcase
        end
        score_d = pos_to_score(pos_d);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= CENTER_POS;
            score_q  <= 7'b0001000;
            led_q    <= LEDCTL_OFF;
            winner_q <= WIN_NONE;
            pen_l_q  <= 1'b0;
            pen_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            score_q  <= score_d;
            led_q    <= led_d;
            winner_q <= winner_d;
            pen_l_q  <= pen_l_d;
            pen_r_q  <= pen_r_d;
        end
    end

    assign score       = score_q;
    assign led_control = led_q;
    assign winner      = winner_q;

endmodule
